// File: rtl/pc_branch_unit.sv
// Program counter and control-transfer resolution: branch condition decode, target
// generation, misaligned-target trap, and retired/taken branch counters.
module pc_branch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [2:0]  funct3,
   input  logic        Br_Eq,
   input  logic        Br_Lt,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        fault_ack,
   output logic        Br_Un,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        taken,
   output logic        fault,
   output logic [31:0] bad_addr,
   output logic        illegal_br,
   output logic [31:0] br_cnt,
   output logic [31:0] taken_cnt
);

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StFault = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] bad_addr_q, bad_addr_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] taken_cnt_q, taken_cnt_d;

   logic        sel_jalr, sel_jal, sel_branch;
   logic        br_cond;
   logic        br_reserved;
   logic [31:0] pc_rel_target;
   logic [31:0] jalr_sum;
   logic [31:0] target;
   logic        taken_int;
   logic        misaligned;

   // Priority select: JALR wins over JAL, JAL wins over a conditional branch.
   assign sel_jalr   = is_jalr;
   assign sel_jal    = is_jal & ~is_jalr;
   assign sel_branch = is_branch & ~is_jal & ~is_jalr;

   assign br_reserved = (funct3[2:1] == 2'b01);

   always_comb begin
      br_cond = 1'b0;
      unique case (funct3)
         3'b000:  br_cond = Br_Eq;
         3'b001:  br_cond = ~Br_Eq;
         3'b100:  br_cond = Br_Lt;
         3'b101:  br_cond = ~Br_Lt;
         3'b110:  br_cond = Br_Lt;
         3'b111:  br_cond = ~Br_Lt;
         default: br_cond = 1'b0;
      endcase
   end

   assign pc_rel_target = pc_q + imm;
   assign jalr_sum      = rs1_data + imm;

   always_comb begin
      target = pc_rel_target;
      if (sel_jalr) begin
         target = {jalr_sum[31:1], 1'b0};
      end
   end

   always_comb begin
      taken_int = 1'b0;
      if (state_q == StRun) begin
         taken_int = sel_jalr | sel_jal | (sel_branch & br_cond);
      end
   end

   assign misaligned = taken_int & (target[1:0] != 2'b00);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      bad_addr_d  = bad_addr_q;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (!stall) begin
         unique case (state_q)
            StRun: begin
               if (sel_branch) begin
                  br_cnt_d = br_cnt_q + 32'd1;
                  if (taken_int) begin
                     taken_cnt_d = taken_cnt_q + 32'd1;
                  end
               end
               if (misaligned) begin
                  state_d    = StFault;
                  pc_d       = TRAP_VEC;
                  bad_addr_d = target;
               end else if (taken_int) begin
                  pc_d = target;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
            StFault: begin
               if (fault_ack) begin
                  state_d = StRun;
                  pc_d    = TRAP_VEC + 32'd4;
               end
            end
            default: begin
               state_d = StRun;
               pc_d    = RESET_PC;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         pc_q        <= RESET_PC;
         bad_addr_q  <= 32'd0;
         br_cnt_q    <= 32'd0;
         taken_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         bad_addr_q  <= bad_addr_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign Br_Un      = funct3[1];
   assign pc         = pc_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign taken      = taken_int;
   assign fault      = (state_q == StFault);
   assign bad_addr   = bad_addr_q;
   assign illegal_br = is_branch & br_reserved;
   assign br_cnt     = br_cnt_q;
   assign taken_cnt  = taken_cnt_q;

endmodule
